aes128_key_expand_seq: RTL

Sequential AES-128 key-expansion engine. Accepts a 128-bit cipher key over a valid/ready handshake and computes one key-schedule round per clock, producing round keys 1..10. All 11 round keys (slot 0 = cipher key) are stored in an internal register file. The downstream encryption round datapath reads them by index.

---
 rtl/aes128_key_expand_seq_if.sv | 30 +++
 rtl/aes128_key_expand_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/aes128_key_expand_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : aes128_key_expand_seq_if
// Description : Key-load handshake, status and round-key read bus of the
//               AES-128 sequential key-expansion engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes128_key_expand_seq_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  // Key source / round-key consumer side
  modport master (
    output key_valid, key_in, rd_idx,
    input  key_ready, busy, done, keys_valid, rd_key
  );

  // Key-expansion engine side
  modport slave (
    input  key_valid, key_in, rd_idx,
    output key_ready, busy, done, keys_valid, rd_key
  );
endinterface
`default_nettype wire

// File: rtl/aes128_key_expand_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes128_key_expand_seq
// Description : Sequential AES-128 key expansion. One schedule round per
//               clock; slot 0 holds the cipher key, slots 1..10 the round
//               keys. Round keys are read back by index.
//               Build option KEYEXP_RDREG_EN registers the read port (one
//               cycle of read latency); otherwise the read is combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module aes128_key_expand_seq #(
  parameter int NROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes128_key_expand_seq_if.slave bus
);

  localparam int NSLOTS = NROUNDS + 1;

  // AES S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  // Byte b sits at bit offset (255-b)*8, which is simply {~b, 3'b000}
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos  = {~b, 3'b000};
    return SBOX[pos +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  // One schedule round: previous round key + rcon -> next round key
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       state_q, state_d;
  logic [127:0] slot_q [NSLOTS];
  logic [127:0] slot_d [NSLOTS];
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;
  logic         keys_valid_q, keys_valid_d;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [127:0] rd_key_d;

  // Select the previous slot so a single step datapath is shared by all rounds
  always_comb begin
    prev_key = '0;
    for (int k = 0; k < NROUNDS; k++) begin
      if (round_q == 4'(k + 1)) prev_key = slot_q[k];
    end
    next_key = key_step(prev_key, rcon_q);
  end

  // Next-state logic: key acceptance in IDLE, one round per cycle in EXPAND
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    round_d      = round_q;
    rcon_d       = rcon_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          slot_d[0]    = bus.key_in;
          round_d      = 4'd1;
          rcon_d       = 8'h01;
          keys_valid_d = 1'b0;
          state_d      = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        for (int k = 1; k < NSLOTS; k++) begin
          if (round_q == 4'(k)) slot_d[k] = next_key;
        end
        rcon_d  = xtime(rcon_q);
        round_d = round_q + 4'd1;
        if (round_q == 4'(NROUNDS)) begin
          state_d      = ST_IDLE;
          done_d       = 1'b1;
          keys_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, key store and status registers; reset clears the whole schedule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      for (int k = 0; k < NSLOTS; k++) slot_q[k] <= '0;
      round_q      <= 4'd0;
      rcon_q       <= 8'h01;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      round_q      <= round_d;
      rcon_q       <= rcon_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  // Read mux; indices beyond the last slot return zero
  always_comb begin
    rd_key_d = '0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (bus.rd_idx == 4'(k)) rd_key_d = slot_q[k];
    end
  end

`ifdef KEYEXP_RDREG_EN
  logic [127:0] rd_key_q;

  // Registered read port: one cycle of read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_key_q <= '0;
    else        rd_key_q <= rd_key_d;
  end

  assign bus.rd_key = rd_key_q;
`else
  assign bus.rd_key = rd_key_d;
`endif

  assign bus.key_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_EXPAND);
  assign bus.done       = done_q;
  assign bus.keys_valid = keys_valid_q;

endmodule
`default_nettype wire
